// File: rtl/log2_fixed.sv
// Iterative fixed-point log2: the integer part comes from leading-one detection, and the
// fraction bits come from repeated squaring of the normalised mantissa. Runs free, with no handshake.
module log2_fixed #(
  parameter int unsigned W       = 9,
  parameter int unsigned E_INT   = 4,
  parameter int unsigned D_FRAC  = 3,
  parameter int unsigned IN_FRAC = 0,
  parameter int unsigned MW      = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] valor,
  output logic [W-1:0] saida
);

  localparam int unsigned KW = $clog2(W);
  localparam int unsigned IW = (D_FRAC > 1) ? $clog2(D_FRAC) : 1;

  typedef enum logic [1:0] {StLoad, StNorm, StIter, StDone} state_e;

  state_e              state_q, state_d;
  logic [W-1:0]        operand_q, operand_d;
  logic [MW-1:0]       m_q, m_d;
  logic [W-1:0]        int_q, int_d;
  logic [D_FRAC-1:0]   frac_q, frac_d;
  logic [IW-1:0]       iter_q, iter_d;
  logic                invalid_q, invalid_d;
  logic [W-1:0]        saida_q, saida_d;

  logic [KW-1:0]       k;
  logic [MW-1:0]       mant_norm;
  logic [2*MW-1:0]     sq;
  logic [W-1:0]        result;
  logic                unused_sq_low;

  // Position of the most-significant one among the magnitude bits.
  always_comb begin
    k = '0;
    for (int unsigned b = 0; b < W - 1; b++) begin
      if (operand_q[b]) k = KW'(b);
    end
  end

  assign mant_norm = MW'(operand_q[W-2:0]) << (MW - 1 - k);

  // m is in Q1.(MW-1), so the square is in Q2.(2MW-2). The top MW+1 bits give Q2.(MW-1).
  assign sq            = {{MW{1'b0}}, m_q} * {{MW{1'b0}}, m_q};
  assign unused_sq_low = ^sq[MW-2:0];

  assign result = (int_q << D_FRAC) | W'(frac_q);

  always_comb begin
    state_d   = state_q;
    operand_d = operand_q;
    m_d       = m_q;
    int_d     = int_q;
    frac_d    = frac_q;
    iter_d    = iter_q;
    invalid_d = invalid_q;
    saida_d   = saida_q;

    unique case (state_q)
      StLoad: begin
        operand_d = valor;
        invalid_d = 1'b0;
        frac_d    = '0;
        state_d   = StNorm;
      end
      StNorm: begin
        iter_d = IW'(D_FRAC - 1);
        if (operand_q[W-1] || (operand_q == '0)) begin
          invalid_d = 1'b1;
          m_d       = '0;
          int_d     = '0;
        end else begin
          m_d   = mant_norm;
          int_d = W'(k) - W'(IN_FRAC);
        end
        state_d = StIter;
      end
      StIter: begin
        frac_d[iter_q] = sq[2*MW-1];
        if (sq[2*MW-1]) begin
          m_d = sq[2*MW-1:MW];
        end else begin
          m_d = sq[2*MW-2:MW-1];
        end
        if (iter_q == '0) begin
          state_d = StDone;
        end else begin
          iter_d = iter_q - IW'(1);
        end
      end
      StDone: begin
        saida_d = invalid_q ? {1'b1, {(W-1){1'b0}}} : result;
        state_d = StLoad;
      end
      default: state_d = StLoad;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StLoad;
      operand_q <= '0;
      m_q       <= '0;
      int_q     <= '0;
      frac_q    <= '0;
      iter_q    <= '0;
      invalid_q <= 1'b0;
      saida_q   <= '0;
    end else begin
      state_q   <= state_d;
      operand_q <= operand_d;
      m_q       <= m_d;
      int_q     <= int_d;
      frac_q    <= frac_d;
      iter_q    <= iter_d;
      invalid_q <= invalid_d;
      saida_q   <= saida_d;
    end
  end

  assign saida = saida_q;

  // The result must fit in W bits, and the mantissa must hold every magnitude bit.
  always_ff @(posedge clk) begin
    assert ((E_INT + D_FRAC + 1 <= W) && (MW - 1 >= W - 2));
  end

endmodule

// File: tb/tb_log2_fixed.sv
// Directed testbench for log2_fixed using the default parameters (W=9, D_FRAC=3, period of 6 cycles).
module tb_log2_fixed;

  logic       clk;
  logic       rst;
  logic [8:0] valor;
  logic [8:0] saida;

  int checks;
  int passes;

  log2_fixed dut (
    .clk  (clk),
    .rst  (rst),
    .valor(valor),
    .saida(saida)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset, the first-result latency, and holding the result while the input is unchanged.
  task automatic test_reset();
    rst   = 1'b1;
    valor = 9'd5;
    step();
    checks++;
    if (saida !== 9'd0) $display("FAIL reset_value: got %0d expected 0", saida);
    else passes++;
    rst = 1'b0;
    for (int e = 1; e <= 5; e++) begin
      step();
      checks++;
      if (saida !== 9'd0) $display("FAIL latency_edge%0d: got %0d expected 0", e, saida);
      else passes++;
    end
    step();
    checks++;
    if (saida !== 9'd18) $display("FAIL first_result_5: got %0d expected 18", saida);
    else passes++;
    for (int e = 1; e <= 6; e++) begin
      step();
      checks++;
      if (saida !== 9'd18) $display("FAIL hold_5_edge%0d: got %0d expected 18", e, saida);
      else passes++;
    end
  endtask

  // Powers of two give exact results. Each loop starts just after a result edge.
  task automatic test_powers();
    logic [8:0] vin [3];
    logic [8:0] vexp[3];
    logic [8:0] prev;
    vin  = '{9'd1, 9'd2, 9'd8};
    vexp = '{9'd0, 9'd8, 9'd24};
    prev = 9'd18;
    for (int n = 0; n < 3; n++) begin
      valor = vin[n];
      repeat (3) step();
      checks++;
      if (saida !== prev) $display("FAIL pow_hold_%0d: got %0d expected %0d", vin[n], saida, prev);
      else passes++;
      repeat (3) step();
      checks++;
      if (saida !== vexp[n])
        $display("FAIL pow_%0d: got %0d expected %0d", vin[n], saida, vexp[n]);
      else passes++;
      prev = vexp[n];
    end
  endtask

  // Inputs that are not powers of two produce truncated fraction bits.
  task automatic test_fraction();
    logic [8:0] vin [3];
    logic [8:0] vexp[3];
    vin  = '{9'd3, 9'd255, 9'd5};
    vexp = '{9'd12, 9'd63, 9'd18};
    for (int n = 0; n < 3; n++) begin
      valor = vin[n];
      repeat (6) step();
      checks++;
      if (saida !== vexp[n])
        $display("FAIL frac_%0d: got %0d expected %0d", vin[n], saida, vexp[n]);
      else passes++;
    end
  endtask

  // Zero and negative inputs produce the sentinel value.
  task automatic test_invalid();
    logic [8:0] vin[2];
    vin = '{9'd0, 9'h1FD};
    for (int n = 0; n < 2; n++) begin
      valor = vin[n];
      repeat (6) step();
      checks++;
      if (saida !== 9'h100)
        $display("FAIL sentinel_%0h: got %0h expected 100", vin[n], saida);
      else passes++;
    end
  endtask

  // The operand is latched at LOAD; a change afterwards only affects the next period.
  task automatic test_mid_change();
    valor = 9'd5;
    step();
    step();
    valor = 9'd8;
    repeat (4) step();
    checks++;
    if (saida !== 9'd18) $display("FAIL mid_change_current: got %0d expected 18", saida);
    else passes++;
    repeat (5) step();
    checks++;
    if (saida !== 9'd18) $display("FAIL mid_change_hold: got %0d expected 18", saida);
    else passes++;
    step();
    checks++;
    if (saida !== 9'd24) $display("FAIL mid_change_next: got %0d expected 24", saida);
    else passes++;
  endtask

  // Reset during ITER clears the output and restarts the full latency.
  task automatic test_reset_mid();
    valor = 9'd3;
    repeat (3) step();
    rst = 1'b1;
    step();
    checks++;
    if (saida !== 9'd0) $display("FAIL reset_mid_clear: got %0d expected 0", saida);
    else passes++;
    rst = 1'b0;
    for (int e = 1; e <= 5; e++) begin
      step();
      checks++;
      if (saida !== 9'd0) $display("FAIL reset_mid_edge%0d: got %0d expected 0", e, saida);
      else passes++;
    end
    step();
    checks++;
    if (saida !== 9'd12) $display("FAIL reset_mid_result: got %0d expected 12", saida);
    else passes++;
  endtask

  initial begin
    checks = 0;
    passes = 0;
    rst    = 1'b1;
    valor  = 9'd0;
    test_reset();
    test_powers();
    test_fraction();
    test_invalid();
    test_mid_change();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
